// File: rtl/seq_mult_pkg.sv
// Shared constants for the sequential shift-and-add multiplier:
// FSM state encoding and the default operand width.
package seq_mult_pkg;

  localparam int SEQ_MULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_shift_add_mult_double_stage.sv
// Combinational x2 stage: out = in << 1, MSB dropped.
// Ports: in [N-1:0] operand, out [N-1:0] doubled value.
module double_stage #(
  parameter int N = 8
) (
  input  logic [N-1:0] in,
  output logic [N-1:0] out
);

  assign out = {in[N-2:0], 1'b0};

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier, one bit of b per cycle.
// Ports: clk, rst (async, active-high); in_valid/in_ready + a, b operands;
// out_valid/out_ready + product (2*WIDTH bits, registered); busy in RUN.
// Define SEQ_MULT_EARLY_EXIT_EN to leave RUN once the multiplier is spent.
module seq_shift_add_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = SEQ_MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    product_q, product_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [PW-1:0]    mcand_dbl;
  logic [PW-1:0]    acc_sum;
  logic [WIDTH-1:0] mplier_shr;
  logic             last_iter;

  double_stage #(
    .N(PW)
  ) u_dbl (
    .in (mcand_q),
    .out(mcand_dbl)
  );

  always_comb begin
    mplier_shr = mplier_q >> 1;
    acc_sum    = mplier_q[0] ? acc_q + mcand_q : acc_q;
`ifdef SEQ_MULT_EARLY_EXIT_EN
    // No remaining multiplier bits means acc is already final.
    last_iter  = (cnt_q == CNT_LAST) || (mplier_shr == '0);
`else
    last_iter  = (cnt_q == CNT_LAST);
`endif
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    product_d = product_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mcand_d  = PW'(a);
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_dbl;
        mplier_d = mplier_shr;
        cnt_d    = cnt_q + CW'(1);
        if (last_iter) begin
          product_d = acc_sum;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN);
  assign product   = product_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench for seq_shift_add_mult: directed cases plus
// 200 random operand pairs scored against a queue of a*b products.
module tb_seq_shift_add_mult;
  import seq_mult_pkg::*;

  localparam int W  = SEQ_MULT_WIDTH;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_shift_add_mult #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .busy     (busy)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Cycles from accept edge to out_valid.
  function automatic int exp_lat(input logic [W-1:0] bv);
    int l;
    l = W;
`ifdef SEQ_MULT_EARLY_EXIT_EN
    l = 1;
    for (int i = 0; i < W; i++)
      if (bv[i]) l = i + 1;
`endif
    return l;
  endfunction

  task automatic run_op(input logic [W-1:0] av,
                        input logic [W-1:0] bv,
                        input int hold,
                        input bit poke,
                        output logic [PW-1:0] prod);
    int g, lat, bc;
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("in_ready_idle", in_ready, 1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    lat = 0;
    bc = 0;
    while (!out_valid && lat < 4 * W + 8) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat(bv));
    check("busy_cycles", bc, exp_lat(bv));
    check("in_ready_done", in_ready, 0);
    prod = product;
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 1) begin
        in_valid = 1'b1;
        a = 1;
        b = 1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("hold_product", product, prod);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after_hs", in_ready, 1);
    check("out_valid_after_hs", out_valid, 0);
  endtask

  logic [PW-1:0] p;
  logic [PW-1:0] q[$];
  int cnt_acc, cnt_got, cyc;
  bit hs_in, hs_out;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_product", product, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    run_op(4'd7, 4'd8, 0, 1'b0, p);
    check("prod_7x8", p, 56);
    run_op(4'd15, 4'd15, 0, 1'b0, p);
    check("prod_15x15", p, 225);
    run_op(4'd0, 4'd9, 0, 1'b0, p);
    check("prod_0x9", p, 0);
    run_op(4'd5, 4'd0, 0, 1'b0, p);
    check("prod_5x0", p, 0);

    run_op(4'd3, 4'd6, 5, 1'b1, p);
    check("prod_3x6_bp", p, 18);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_no_accept_busy", busy, 0);
      check("bp_no_accept_valid", out_valid, 0);
    end

    a = 4'd9;
    b = 4'd9;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrun_rst_in_ready", in_ready, 1);
    check("midrun_rst_out_valid", out_valid, 0);
    check("midrun_rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    run_op(4'd2, 4'd3, 0, 1'b0, p);
    check("prod_2x3", p, 6);

    cnt_acc = 0;
    cnt_got = 0;
    cyc = 0;
    while (cnt_got < 200 && cyc < 20000) begin
      if (cnt_acc < 200) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a = W'($urandom);
        b = W'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = 1'($urandom_range(0, 1));
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      if (hs_in) begin
        q.push_back(PW'(a) * PW'(b));
        cnt_acc++;
      end
      if (hs_out) begin
        if (q.size() == 0) check("spurious_result", 1, 0);
        else check("rand_product", product, q.pop_front());
        cnt_got++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("rand_results", cnt_got, 200);
    check("rand_queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_mult.md
# seq_shift_add_mult

Sequential shift-and-add unsigned multiplier built around the ×2 doubling stage. It accepts two WIDTH-bit operands over a valid/ready handshake. Each cycle it doubles the multiplicand (shift left by one) and conditionally accumulates it, then presents a registered 2·WIDTH-bit product. It sits downstream of operand capture and upstream of any result consumer in the arithmetic datapath.

## Interface
- WIDTH, default 4: operand width in bits; product is 2·WIDTH bits.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a/b valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  product valid (high only in DONE).
- out_ready  input  1  consumer accepts product.
- product  output  2·WIDTH  registered result, unsigned.
- busy  output  1  high in RUN.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On in_valid & in_ready: mcand←zero-extend(a) to 2·WIDTH, mplier←b, acc←0, cnt←0; go to RUN.
- RUN, one iteration per cycle:
  - if mplier[0], acc←acc+mcand;
  - mcand←mcand<<1 (doubling; bits shifted past 2·WIDTH are dropped);
  - mplier←mplier>>1; cnt←cnt+1.
  - After iteration WIDTH (cnt reaches WIDTH): product←final acc; go to DONE.
- DONE: out_valid=1; product held stable. On out_valid & out_ready: go to IDLE.
- Inputs are ignored outside IDLE. a/b may change freely after the accept edge.
- Width rule: acc and mcand are 2·WIDTH bits. Overflow is impossible because (2^W−1)² < 2^(2W). No saturation or wrap logic is present.
- Reset, including mid-RUN or mid-DONE: the operation is aborted with no output, and the FSM returns to IDLE.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, product=0; all internal registers 0; state IDLE.
- Accept at edge E0. RUN iterations occur at edges E1..E_WIDTH. out_valid rises in the cycle after E_WIDTH, so latency is WIDTH cycles from the accept edge to out_valid.
- Throughput: one result per WIDTH+2 cycles minimum. Accept, DONE and IDLE are never overlapped.
- Backpressure: out_ready low holds DONE indefinitely; product and out_valid stay stable.
- A product handshake at edge Ed puts the FSM in IDLE; in_ready=1 in the following cycle.
- in_ready, out_valid and busy are decoded from state only, with no combinational path from inputs.

## Configuration
- SEQ_MULT_EARLY_EXIT_EN defined: in RUN, if the post-shift mplier is zero, go to DONE after the current iteration.
  - Latency becomes 1..WIDTH cycles: b=0 and b=1 give 1 cycle; the top bit of b set gives WIDTH cycles.
  - product is identical to the non-early-exit result.
- Undefined: exactly WIDTH RUN iterations always; cnt is the sole exit condition.

## Structure
- Shared package seq_mult_pkg holds:
  - the state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the default WIDTH constant.
- One sub-module: double_stage (parameter N; combinational out = in<<1, N-bit in, N-bit out). It is instantiated on the mcand path.
- Counter width is $clog2(WIDTH+1).

## Test plan
- Reset release: in_ready=1, out_valid=0, product=0, busy=0.
- a=7, b=8, in_valid one cycle: out_valid exactly 4 cycles after the accept edge (without EN), product=56; busy high for 4 cycles.
- a=15, b=15: product=225. Then a=0, b=9: product=0. With SEQ_MULT_EARLY_EXIT_EN, a=5, b=0 gives out_valid 1 cycle after accept with product=0.
- Backpressure on a=3, b=6: hold out_ready=0 for 5 cycles and pulse in_valid with a=1, b=1 during DONE. product stays 18, in_ready stays 0, and the new operands are not accepted.
- Assert rst during RUN on a=9, b=9: the cycle after rst shows IDLE, in_ready=1, out_valid=0. Release rst, then a=2, b=3 gives product=6.
- 200 back-to-back random operand pairs with random out_ready: each product equals a·b, no result is lost or duplicated, and ordering is preserved.
